icache_responder: RTL

- Instruction-cache responder on the fetch-side Icache bus.
- Fetch drives a 32-bit byte address and samples a 33-bit {miss, instr} return in the same cycle, so hit data is combinational.
- Direct-mapped cache with a word-serial refill state machine toward instruction memory.
- Sits between the fetch stage and the memory/bus interface.
- The miss flag is consumed by the hazard logic to stall the PC.

---
 rtl/icache_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache with word-serial refill
// Optional hit/miss counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_responder #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] i_fetch_addr,
  output logic [32:0] o_fetch_bus,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int OFF    = $clog2(WORDS_PER_LINE);
  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = 30 - OFF - IDX;
  localparam int BASE_W = TAG_W + IDX;

  typedef enum logic {IDLE, FILL} state_t;

  logic [OFF-1:0]   f_word;
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [1:0]       unused_addr_bits;

  assign f_word           = i_fetch_addr[OFF+1:2];
  assign f_idx            = i_fetch_addr[IDX+OFF+1:OFF+2];
  assign f_tag            = i_fetch_addr[31:IDX+OFF+2];
  assign unused_addr_bits = i_fetch_addr[1:0];

  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF-1:0]    cnt_q, cnt_d;
  logic              discard_q, discard_d;

  logic             hit;
  logic             miss;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             last_word;
  logic             fill_start;
  logic             fill_done;
  logic             data_we;

  assign hit        = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
  assign miss       = !hit;
  assign fill_idx   = base_q[IDX-1:0];
  assign fill_tag   = base_q[BASE_W-1:IDX];
  assign last_word  = (cnt_q == {OFF{1'b1}});
  assign fill_start = (state_q == IDLE) && !i_flush && miss;
  assign data_we    = (state_q == FILL) && i_mem_ack;
  assign fill_done  = data_we && last_word;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // Data and tag arrays carry no reset; the valid vector alone decides what is served.
  always_ff @(posedge Clk) begin
    if (data_we) begin
      data_mem[{fill_idx, cnt_q}] <= i_mem_rdata;
    end
    if (fill_done) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start) state_d = FILL;
      FILL:    if (fill_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    if (state_q == IDLE) begin
      if (i_flush) begin
        valid_d = '0;
      end else if (miss) begin
        base_d          = {f_tag, f_idx};
        valid_d[f_idx]  = 1'b0;
        cnt_d           = '0;
        discard_d       = 1'b0;
      end
    end else begin
      if (i_flush) begin
        valid_d   = '0;
        discard_d = 1'b1;
      end
      if (i_mem_ack) begin
        cnt_d = cnt_q + 1'b1;
      end
      // A flush seen at any point of the refill keeps the completed line invalid.
      if (fill_done && !discard_q && !i_flush) begin
        valid_d[fill_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_req   = (state_q == FILL);
    o_mem_addr  = '0;
    o_fetch_bus = '0;
    if (state_q == FILL) begin
      o_mem_addr = {base_q, cnt_q, 2'b00};
    end
    if (!Rst) begin
      o_fetch_bus = hit ? {1'b0, data_mem[{f_idx, f_word}]} : {1'b1, 32'h0};
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (fill_start) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule
